// File: rtl/snake_body_streamer.sv
// Snake segment store: moves/grows the snake, detects self/wall collision and streams
// all segments to the renderer once per frame. Define SNAKE_WALL_WRAP_EN for wrap-around edges.
module snake_body_streamer #(
    parameter int MAX_LEN  = 32,
    parameter int LEN_BIT  = 6,
    parameter int GRID_W   = 124,
    parameter int GRID_H   = 81,
    parameter int INIT_LEN = 4
) (
    input  logic               clock_25,
    input  logic               reset,
    input  logic               move_tick,
    input  logic [1:0]         direction,
    input  logic               grow,
    input  logic               frame_start,
    output logic [6:0]         snake_head_x,
    output logic [6:0]         snake_head_y,
    output logic [6:0]         snake_body_x,
    output logic [6:0]         snake_body_y,
    output logic               en_snake_body,
    output logic [LEN_BIT-1:0] snake_length,
    output logic               busy,
    output logic               collision,
    output logic [2:0]         fsm_state
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        STREAM = 3'd1,
        SHIFT  = 3'd2,
        HEAD   = 3'd3,
        GAP    = 3'd4
    } state_t;

    localparam int IDX_W = $clog2(MAX_LEN);
    localparam logic [6:0] X_MAX = 7'(GRID_W - 1);
    localparam logic [6:0] Y_MAX = 7'(GRID_H - 1);
    localparam logic [LEN_BIT-1:0] LEN_MAX = LEN_BIT'(MAX_LEN);
    localparam logic [LEN_BIT-1:0] LEN_ONE = LEN_BIT'(1);
    localparam logic [IDX_W-1:0]   IDX_ONE = IDX_W'(1);
    localparam logic [IDX_W-1:0]   IDX_TWO = IDX_W'(2);
`ifdef SNAKE_WALL_WRAP_EN
    localparam bit WALL_WRAP = 1'b1;
`else
    localparam bit WALL_WRAP = 1'b0;
`endif

    state_t             state, state_next;
    logic [IDX_W-1:0]   idx;
    logic [6:0]         seg_x [MAX_LEN];
    logic [6:0]         seg_y [MAX_LEN];
    logic [1:0]         cur_dir;
    logic               pend_frame, pend_move, pend_grow;
    logic [1:0]         pend_dir;
    logic               mv_grow;
    logic [6:0]         nh_x, nh_y;

    logic [1:0]         src_dir, eff_dir;
    logic               src_grow, grow_ok;
    logic [6:0]         cand_x, cand_y;
    logic               edge_cross, hit_wall;
    logic [IDX_W-1:0]   top;
    logic               do_stream, do_move, last_seg, body_hit;

    // Handshake: en_snake_body high means snake_body_x/y hold seg[k], k counting up from 0
    // by one per cycle; no back-pressure; every burst is followed by at least one low cycle.
    always_comb begin
        src_dir    = pend_move ? pend_dir : direction;
        src_grow   = pend_move ? pend_grow : grow;
        eff_dir    = ((src_dir ^ 2'b10) == cur_dir) ? cur_dir : src_dir;
        grow_ok    = src_grow && (snake_length < LEN_MAX);
        top        = grow_ok ? IDX_W'(snake_length) : IDX_W'(snake_length - LEN_ONE);
        cand_x     = seg_x[0];
        cand_y     = seg_y[0];
        edge_cross = 1'b0;
        case (eff_dir)
            2'b00: if (seg_y[0] == 7'd0) begin edge_cross = 1'b1; cand_y = Y_MAX; end
                   else cand_y = seg_y[0] - 7'd1;
            2'b01: if (seg_x[0] == X_MAX) begin edge_cross = 1'b1; cand_x = 7'd0; end
                   else cand_x = seg_x[0] + 7'd1;
            2'b10: if (seg_y[0] == Y_MAX) begin edge_cross = 1'b1; cand_y = 7'd0; end
                   else cand_y = seg_y[0] + 7'd1;
            default: if (seg_x[0] == 7'd0) begin edge_cross = 1'b1; cand_x = X_MAX; end
                   else cand_x = seg_x[0] - 7'd1;
        endcase
        hit_wall  = edge_cross && !WALL_WRAP;
        do_stream = frame_start || pend_frame;
        do_move   = move_tick || pend_move;
        last_seg  = (idx == IDX_W'(snake_length - LEN_ONE));
        body_hit  = (idx >= IDX_TWO) && (seg_x[idx - IDX_ONE] == nh_x) &&
                    (seg_y[idx - IDX_ONE] == nh_y);

        state_next = state;
        case (state)
            IDLE:    if (do_stream) state_next = STREAM;
                     else if (do_move && !hit_wall) state_next = SHIFT;
            STREAM:  if (last_seg) state_next = GAP;
            SHIFT:   if (idx == IDX_ONE) state_next = HEAD;
            HEAD:    state_next = IDLE;
            GAP:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock_25) begin
        if (reset) begin
            state        <= IDLE;
            idx          <= '0;
            snake_length <= LEN_BIT'(INIT_LEN);
            cur_dir      <= 2'b01;
            collision    <= 1'b0;
            pend_frame   <= 1'b0;
            pend_move    <= 1'b0;
            pend_dir     <= 2'b00;
            pend_grow    <= 1'b0;
            mv_grow      <= 1'b0;
            nh_x         <= '0;
            nh_y         <= '0;
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x[i] <= 7'(GRID_W / 2 - i);
                seg_y[i] <= 7'(GRID_H / 2);
            end
        end else begin
            state <= state_next;
            // Events seen while busy are parked; only the first pending move is kept.
            if (state != IDLE) begin
                if (frame_start) pend_frame <= 1'b1;
                if (move_tick && !pend_move) begin
                    pend_move <= 1'b1;
                    pend_dir  <= direction;
                    pend_grow <= grow;
                end
            end
            case (state)
                IDLE: begin
                    if (do_stream) begin
                        idx        <= '0;
                        pend_frame <= 1'b0;
                        if (move_tick && !pend_move) begin
                            pend_move <= 1'b1;
                            pend_dir  <= direction;
                            pend_grow <= grow;
                        end
                    end else if (do_move) begin
                        pend_move <= 1'b0;
                        if (hit_wall) begin
                            collision <= 1'b1;
                        end else begin
                            idx     <= top;
                            mv_grow <= grow_ok;
                            nh_x    <= cand_x;
                            nh_y    <= cand_y;
                            cur_dir <= eff_dir;
                        end
                    end
                end
                STREAM: if (!last_seg) idx <= idx + IDX_ONE;
                SHIFT: begin
                    seg_x[idx] <= seg_x[idx - IDX_ONE];
                    seg_y[idx] <= seg_y[idx - IDX_ONE];
                    if (body_hit) collision <= 1'b1;
                    idx <= idx - IDX_ONE;
                end
                HEAD: begin
                    seg_x[0] <= nh_x;
                    seg_y[0] <= nh_y;
                    if (mv_grow) snake_length <= snake_length + LEN_ONE;
                end
                default: ;
            endcase
        end
    end

    assign snake_head_x  = seg_x[0];
    assign snake_head_y  = seg_y[0];
    assign en_snake_body = (state == STREAM);
    assign snake_body_x  = en_snake_body ? seg_x[idx] : 7'd0;
    assign snake_body_y  = en_snake_body ? seg_y[idx] : 7'd0;
    assign busy          = (state != IDLE);
    assign fsm_state     = state;

endmodule

// File: tb/tb_snake_body_streamer.sv
// Directed bench for snake_body_streamer: reset, streaming, moves, growth, wrap/wall,
// arbitration of pending events, self-collision and reset during a stream.
module tb_snake_body_streamer;

    logic       clock_25 = 1'b0;
    logic       reset, move_tick, grow, frame_start;
    logic [1:0] direction;
    logic [6:0] snake_head_x, snake_head_y, snake_body_x, snake_body_y;
    logic       en_snake_body, busy, collision;
    logic [5:0] snake_length;
    logic [2:0] fsm_state;

    int checks = 0;
    int errors = 0;
    int n;

    snake_body_streamer dut (
        .clock_25      (clock_25),
        .reset         (reset),
        .move_tick     (move_tick),
        .direction     (direction),
        .grow          (grow),
        .frame_start   (frame_start),
        .snake_head_x  (snake_head_x),
        .snake_head_y  (snake_head_y),
        .snake_body_x  (snake_body_x),
        .snake_body_y  (snake_body_y),
        .en_snake_body (en_snake_body),
        .snake_length  (snake_length),
        .busy          (busy),
        .collision     (collision),
        .fsm_state     (fsm_state)
    );

    always #20 clock_25 = ~clock_25;

    task automatic step();
        @(posedge clock_25);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        move_tick = 1'b0;
        frame_start = 1'b0;
        grow = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic do_move(input logic [1:0] d, input logic g);
        direction = d;
        grow = g;
        move_tick = 1'b1;
        step();
        move_tick = 1'b0;
        grow = 1'b0;
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (busy === 1'b1 && cyc < 1000) begin
            step();
            cyc++;
        end
        check("idle_timeout", busy, 0);
    endtask

    // Straight horizontal body: segment k sits at (x0-k, y).
    task automatic check_stream(input string tag, input int len, input int x0, input int y);
        for (int k = 0; k < len; k++) begin
            check({tag, "_en"}, en_snake_body, 1);
            check({tag, "_x"}, snake_body_x, x0 - k);
            check({tag, "_y"}, snake_body_y, y);
            step();
        end
        check({tag, "_gap"}, en_snake_body, 0);
    endtask

    initial begin
        direction = 2'b01;
        do_reset();
        check("rst_en", en_snake_body, 0);
        check("rst_busy", busy, 0);
        check("rst_coll", collision, 0);
        check("rst_len", snake_length, 4);
        check("rst_head_x", snake_head_x, 62);
        check("rst_head_y", snake_head_y, 40);
        check("rst_body_x", snake_body_x, 0);
        check("rst_body_y", snake_body_y, 0);
        check("rst_state", fsm_state, 0);

        pulse_frame();
        check("boot_state", fsm_state, 1);
        check_stream("boot", 4, 62, 40);
        wait_idle(n);

        do_move(2'b01, 1'b0);
        check("move_state", fsm_state, 2);
        wait_idle(n);
        check("move_latency", n, 4);
        check("move_head_x", snake_head_x, 63);
        check("move_head_y", snake_head_y, 40);
        check("move_len", snake_length, 4);
        pulse_frame();
        check_stream("after_move", 4, 63, 40);
        wait_idle(n);

        do_move(2'b11, 1'b0);
        wait_idle(n);
        check("reverse_head_x", snake_head_x, 64);
        check("reverse_head_y", snake_head_y, 40);

        do_move(2'b01, 1'b1);
        wait_idle(n);
        check("grow_latency", n, 5);
        check("grow_len", snake_length, 5);
        for (int i = 0; i < 27; i++) begin
            do_move(2'b01, 1'b1);
            wait_idle(n);
        end
        check("grow_len_max", snake_length, 32);
        do_move(2'b01, 1'b1);
        wait_idle(n);
        check("sat_len", snake_length, 32);
        check("sat_head_x", snake_head_x, 93);
        pulse_frame();
        check_stream("full", 32, 93, 40);
        wait_idle(n);

        for (int i = 0; i < 30; i++) begin
            do_move(2'b01, 1'b0);
            wait_idle(n);
        end
        check("edge_head_x", snake_head_x, 123);
        check("edge_coll", collision, 0);
        do_move(2'b01, 1'b0);
        wait_idle(n);
        check("wall_head_y", snake_head_y, 40);
`ifdef SNAKE_WALL_WRAP_EN
        check("wrap_head_x", snake_head_x, 0);
        check("wrap_coll", collision, 0);
`else
        check("wall_head_x", snake_head_x, 123);
        check("wall_coll", collision, 1);
`endif

        do_reset();
        check("rst2_coll", collision, 0);
        direction = 2'b01;
        frame_start = 1'b1;
        move_tick = 1'b1;
        step();
        frame_start = 1'b0;
        move_tick = 1'b0;
        check_stream("simul", 4, 62, 40);
        step();
        check("simul_pre_shift_x", snake_head_x, 62);
        step();
        wait_idle(n);
        check("simul_head_x", snake_head_x, 63);

        do_move(2'b01, 1'b0);
        frame_start = 1'b1;
        move_tick = 1'b1;
        direction = 2'b00;
        step();
        frame_start = 1'b0;
        direction = 2'b01;
        step();
        move_tick = 1'b0;
        n = 0;
        while (en_snake_body !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        check("pend_stream_seen", en_snake_body, 1);
        check_stream("pend", 4, 64, 40);
        for (int i = 0; i < 20; i++) step();
        check("pend_head_x", snake_head_x, 64);
        check("pend_head_y", snake_head_y, 39);
        check("pend_busy", busy, 0);

        do_reset();
        do_move(2'b00, 1'b1);
        wait_idle(n);
        check("loop_len", snake_length, 5);
        check("loop_up_coll", collision, 0);
        do_move(2'b11, 1'b0);
        wait_idle(n);
        check("loop_left_coll", collision, 0);
        do_move(2'b10, 1'b0);
        wait_idle(n);
        check("loop_down_coll", collision, 1);
        check("loop_down_x", snake_head_x, 61);
        check("loop_down_y", snake_head_y, 40);
        do_move(2'b01, 1'b0);
        wait_idle(n);
        check("loop_sticky", collision, 1);
        check("loop_right_x", snake_head_x, 62);

        pulse_frame();
        step();
        check("mid_en", en_snake_body, 1);
        reset = 1'b1;
        step();
        check("abort_en", en_snake_body, 0);
        check("abort_busy", busy, 0);
        check("abort_coll", collision, 0);
        reset = 1'b0;
        step();
        check("abort_en_after", en_snake_body, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
